// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: the fetch-to-decode queue entry type and its depth.
package cpu_defs_pkg;

  localparam int INST_QUEUE_DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } inst_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and decode.
// Fetch pushes up to two {pc, inst} pairs per cycle. Decode reads the two
// oldest entries through show-ahead outputs and pops 0, 1 or 2 per cycle.
// A flush empties the queue in one cycle. Storage itself is never reset;
// only the pointers and the count are, and all outputs are gated by count.
module inst_queue
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH = INST_QUEUE_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        i_wen1,
  input  logic [31:0] i_pc1,
  input  logic [31:0] i_inst1,
  input  logic        i_wen2,
  input  logic [31:0] i_pc2,
  input  logic [31:0] i_inst2,
  output logic        o_full,
  input  logic        i_ren1,
  input  logic        i_ren2,
  output logic        o_valid1,
  output logic [31:0] o_pc1,
  output logic [31:0] o_inst1,
  output logic        o_valid2,
  output logic [31:0] o_pc2,
  output logic [31:0] o_inst2,
  output logic        o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  inst_entry_t r_mem [DEPTH];

  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  logic [AW-1:0] w_wrPtrNext1;
  logic [AW-1:0] w_rdPtrNext1;
  logic [CW-1:0] w_npush;
  logic [CW-1:0] w_popReq;
  logic [CW-1:0] w_npop;
  logic          w_full;
  logic          w_valid1;
  logic          w_valid2;
  inst_entry_t   w_head1;
  inst_entry_t   w_head2;

  assign w_wrPtrNext1 = r_wrPtr + AW'(1);
  assign w_rdPtrNext1 = r_rdPtr + AW'(1);

  // Status flags come only from the registered count; a same-cycle pop never lifts full
  assign w_full   = (r_count > CW'(DEPTH - 2));
  assign w_valid1 = (r_count != '0);
  assign w_valid2 = (r_count >= CW'(2));

  // Decide how many entries move this cycle; slot 2 alone and pushes while full are dropped
  always_comb begin
    w_npush  = '0;
    w_popReq = '0;
    if (!flush && !w_full && i_wen1) begin
      w_npush = i_wen2 ? CW'(2) : CW'(1);
    end
    if (i_ren1) begin
      w_popReq = i_ren2 ? CW'(2) : CW'(1);
    end
    w_npop = (w_popReq > r_count) ? r_count : w_popReq;
  end

  // Entry storage: slot 1 lands at wr_ptr, slot 2 at the wrapped next index
  always_ff @(posedge clk) begin
    if (w_npush != '0) begin
      r_mem[r_wrPtr] <= '{pc: i_pc1, inst: i_inst1};
      if (w_npush == CW'(2)) begin
        r_mem[w_wrPtrNext1] <= '{pc: i_pc2, inst: i_inst2};
      end
    end
  end

  // Pointer and occupancy update; flush wins over any push or pop in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      r_wrPtr <= r_wrPtr + AW'(w_npush);
      r_rdPtr <= r_rdPtr + AW'(w_npop);
      r_count <= r_count + w_npush - w_npop;
    end
  end

  // Show-ahead read of the two oldest entries, zeroed whenever they are not valid
  always_comb begin
    w_head1  = r_mem[r_rdPtr];
    w_head2  = r_mem[w_rdPtrNext1];
    o_pc1    = w_valid1 ? w_head1.pc   : '0;
    o_inst1  = w_valid1 ? w_head1.inst : '0;
    o_pc2    = w_valid2 ? w_head2.pc   : '0;
    o_inst2  = w_valid2 ? w_head2.inst : '0;
  end

  assign o_full   = w_full;
  assign o_valid1 = w_valid1;
  assign o_valid2 = w_valid2;
  assign o_empty  = (r_count == '0);

endmodule
